// File: rtl/frac_div_ramp_ctrl_if.sv
// rtl/frac_div_ramp_ctrl_if.sv - configuration handshake bundle for frac_div_ramp_ctrl
// Purpose: carries a new divide target from the register side to the ramp controller.
// Signals:
//    cfg_valid  master->slave  new target offered
//    cfg_ready  slave->master  controller can accept a target
//    cfg_n      master->slave  target integer divide N
//    cfg_mf     master->slave  target signed fractional offset
//    cfg_step   master->slave  max |mf| change per update in LSBs, 0 = jump
//    cfg_rate   master->slave  extra divider periods between updates
interface frac_div_ramp_ctrl_if #(
   parameter int WIDTH = 17
);
   logic                    cfg_valid;
   logic                    cfg_ready;
   logic [WIDTH-1:0]        cfg_n;
   logic signed [WIDTH-1:0] cfg_mf;
   logic [7:0]              cfg_step;
   logic [7:0]              cfg_rate;

   modport master (
      output cfg_valid, cfg_n, cfg_mf, cfg_step, cfg_rate,
      input  cfg_ready
   );

   modport slave (
      input  cfg_valid, cfg_n, cfg_mf, cfg_step, cfg_rate,
      output cfg_ready
   );
endinterface

// File: rtl/frac_div_ramp_ctrl.sv
// rtl/frac_div_ramp_ctrl.sv - fractional divider configuration sequencer with bounded mf ramp
// Purpose: accepts a new (N, mf) target, rebases the current ratio onto the new N without
//          changing frequency, then slews mf toward the target in bounded steps, touching
//          the divider inputs only on divider period boundaries.
// Ports:
//    sys_clk    in   system clock, rising edge
//    sync_rst   in   synchronous active-high reset
//    cfg        slave modport of frac_div_ramp_ctrl_if (target handshake)
//    hold       in   freeze the ramp while high
//    div_count  in   divider count, 0 marks a period boundary
//    div_n      out  N driven to the divider
//    div_mf     out  signed mf driven to the divider
//    busy       out  rebase/ramp in progress
//    locked     out  div_mf equals target and controller idle
//    cfg_err    out  one-cycle pulse when a target is rejected
module frac_div_ramp_ctrl #(
   parameter int               WIDTH = 17,
   parameter int               FSZE  = 3,
   parameter logic [WIDTH-1:0] RST_N = 17'd1000
) (
   input  logic                    sys_clk,
   input  logic                    sync_rst,
   frac_div_ramp_ctrl_if.slave     cfg,
   input  logic                    hold,
   input  logic [WIDTH-1:0]        div_count,
   output logic [WIDTH-1:0]        div_n,
   output logic signed [WIDTH-1:0] div_mf,
   output logic                    busy,
   output logic                    locked,
   output logic                    cfg_err
);

   // Rebase arithmetic width: holds (N difference) * 2^FSZE plus mf with sign headroom.
   localparam int RBW = WIDTH + FSZE + 2;

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_REBASE = 2'd1,
      S_RAMP   = 2'd2
   } state_t;

   state_t                  state_q, state_d;
   logic [WIDTH-1:0]        div_n_q, div_n_d;
   logic signed [WIDTH-1:0] div_mf_q, div_mf_d;
   logic signed [WIDTH-1:0] tgt_mf_q, tgt_mf_d;
   logic [WIDTH-1:0]        new_n_q, new_n_d;
   logic signed [WIDTH-1:0] rb_mf_q, rb_mf_d;
   logic [7:0]              step_q, step_d;
   logic [7:0]              rate_q, rate_d;
   logic [7:0]              rate_cnt_q, rate_cnt_d;
   logic                    busy_q, busy_d;
   logic                    locked_q, locked_d;
   logic                    cfg_err_q, cfg_err_d;

   logic                    bnd;
   logic                    live_bnd;
   logic                    hs;
   logic                    n_ok;
   logic                    rb_ok;
   logic                    accept;
   logic                    reject;
   logic signed [RBW-1:0]   n_delta;
   logic signed [RBW-1:0]   rb_wide;

   logic                    rebase_evt;
   logic                    rebase_on_tgt;
   logic                    ramp_evt;
   logic                    ramp_move;
   logic                    ramp_final;
   logic signed [WIDTH:0]   gap;
   logic [WIDTH:0]          gap_mag;
   logic [WIDTH:0]          step_ext;
   logic signed [WIDTH:0]   mf_next_wide;
   logic signed [WIDTH-1:0] mf_step;

   // Boundary bookkeeping: hold masks boundaries outright, nothing is queued.
   assign bnd      = (div_count == '0);
   assign live_bnd = bnd & ~hold;
   assign hs       = cfg.cfg_valid & (state_q == S_IDLE);

   // Rebase: keep N + mf/2^FSZE constant while N moves to cfg_n.
   always_comb begin
      n_delta = RBW'(div_n_q) - RBW'(cfg.cfg_n);
      rb_wide = RBW'(div_mf_q) + (n_delta <<< FSZE);
      // In range iff every bit above the WIDTH-bit sign position matches it.
      rb_ok   = (rb_wide[RBW-1:WIDTH-1] == '0) || (rb_wide[RBW-1:WIDTH-1] == '1);
      n_ok    = (cfg.cfg_n >= WIDTH'(2));
   end

   assign accept = hs & n_ok & rb_ok;
   assign reject = hs & ~accept;

   // Ramp step, computed one bit wider so the difference never wraps.
   always_comb begin
      gap          = (WIDTH+1)'(tgt_mf_q) - (WIDTH+1)'(div_mf_q);
      gap_mag      = gap[WIDTH] ? unsigned'(-gap) : unsigned'(gap);
      step_ext     = (WIDTH+1)'(step_q);
      ramp_final   = (step_q == 8'd0) || (gap_mag <= step_ext);
      mf_next_wide = gap[WIDTH] ? ((WIDTH+1)'(div_mf_q) - signed'(step_ext))
                                : ((WIDTH+1)'(div_mf_q) + signed'(step_ext));
      // The final update lands exactly on the target, so no overshoot is possible.
      mf_step      = ramp_final ? tgt_mf_q : mf_next_wide[WIDTH-1:0];
   end

   assign rebase_evt    = (state_q == S_REBASE) & live_bnd;
   assign rebase_on_tgt = (rb_mf_q == tgt_mf_q);
   assign ramp_evt      = (state_q == S_RAMP) & live_bnd;
   assign ramp_move     = ramp_evt & (rate_cnt_q == 8'd0);

   // State register together with the datapath flops.
   always_ff @(posedge sys_clk) begin
      if (sync_rst) begin
         state_q    <= S_IDLE;
         div_n_q    <= RST_N;
         div_mf_q   <= '0;
         tgt_mf_q   <= '0;
         new_n_q    <= RST_N;
         rb_mf_q    <= '0;
         step_q     <= '0;
         rate_q     <= '0;
         rate_cnt_q <= '0;
         busy_q     <= 1'b0;
         locked_q   <= 1'b1;
         cfg_err_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         div_n_q    <= div_n_d;
         div_mf_q   <= div_mf_d;
         tgt_mf_q   <= tgt_mf_d;
         new_n_q    <= new_n_d;
         rb_mf_q    <= rb_mf_d;
         step_q     <= step_d;
         rate_q     <= rate_d;
         rate_cnt_q <= rate_cnt_d;
         busy_q     <= busy_d;
         locked_q   <= locked_d;
         cfg_err_q  <= cfg_err_d;
      end
   end

   // Next-state logic.
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE: begin
            if (accept) state_d = S_REBASE;
         end
         S_REBASE: begin
            if (rebase_evt) state_d = rebase_on_tgt ? S_IDLE : S_RAMP;
         end
         S_RAMP: begin
            if (ramp_move && ramp_final) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Datapath next values; div_n and div_mf only ever change on a live boundary.
   always_comb begin
      div_n_d    = div_n_q;
      div_mf_d   = div_mf_q;
      tgt_mf_d   = tgt_mf_q;
      new_n_d    = new_n_q;
      rb_mf_d    = rb_mf_q;
      step_d     = step_q;
      rate_d     = rate_q;
      rate_cnt_d = rate_cnt_q;
      busy_d     = busy_q;
      locked_d   = locked_q;
      cfg_err_d  = 1'b0;

      if (reject) begin
         cfg_err_d = 1'b1;
      end

      if (accept) begin
         tgt_mf_d = cfg.cfg_mf;
         new_n_d  = cfg.cfg_n;
         rb_mf_d  = rb_wide[WIDTH-1:0];
         step_d   = cfg.cfg_step;
         rate_d   = cfg.cfg_rate;
         busy_d   = 1'b1;
         locked_d = 1'b0;
      end

      if (rebase_evt) begin
         div_n_d    = new_n_q;
         div_mf_d   = rb_mf_q;
         rate_cnt_d = rate_q;
         if (rebase_on_tgt) begin
            busy_d   = 1'b0;
            locked_d = 1'b1;
         end
      end

      if (ramp_evt) begin
         if (rate_cnt_q != 8'd0) begin
            rate_cnt_d = rate_cnt_q - 8'd1;
         end else begin
            div_mf_d   = mf_step;
            rate_cnt_d = rate_q;
            if (ramp_final) begin
               busy_d   = 1'b0;
               locked_d = 1'b1;
            end
         end
      end
   end

   // Outputs.
   always_comb begin
      cfg.cfg_ready = (state_q == S_IDLE);
      div_n         = div_n_q;
      div_mf        = div_mf_q;
      busy          = busy_q;
      locked        = locked_q;
      cfg_err       = cfg_err_q;
   end

endmodule

// File: tb/tb_frac_div_ramp_ctrl.sv
// tb/tb_frac_div_ramp_ctrl.sv - self-checking bench for frac_div_ramp_ctrl
module tb_frac_div_ramp_ctrl;
   localparam int W = 17;

   logic                clk = 1'b0;
   logic                rst = 1'b1;
   logic                hold = 1'b0;
   logic [W-1:0]        div_count = 17'd5;
   logic [W-1:0]        div_n;
   logic signed [W-1:0] div_mf;
   logic                busy;
   logic                locked;
   logic                cfg_err;

   frac_div_ramp_ctrl_if #(.WIDTH(W)) cfg_if ();

   frac_div_ramp_ctrl #(.WIDTH(W), .FSZE(3), .RST_N(17'd1000)) dut (
      .sys_clk   (clk),
      .sync_rst  (rst),
      .cfg       (cfg_if.slave),
      .hold      (hold),
      .div_count (div_count),
      .div_n     (div_n),
      .div_mf    (div_mf),
      .busy      (busy),
      .locked    (locked),
      .cfg_err   (cfg_err)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int failures = 0;

   task automatic chk(input string nm, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s actual=%0d expected=%0d t=%0t", nm, act, exp, $time);
      end
   endtask

   // Divider period generator: counts down, 0 is the boundary.
   int per = 16;
   bit rand_per = 1'b0;
   always @(negedge clk) begin
      if (div_count == '0) begin
         if (rand_per) per = $urandom_range(1, 6);
         div_count = W'(per - 1);
      end else begin
         div_count = div_count - 17'd1;
      end
   end

   // Reference model: an accepted target becomes a schedule of (live boundaries to wait,
   // N, mf) updates; outputs follow the schedule, busy while it is non-empty.
   int m_n, m_mf;
   bit m_err;
   bit m_live = 1'b0;
   bit idle_pre;
   int q_wait[$];
   int q_n[$];
   int q_mf[$];

   function automatic void model_accept(int cn, int cmf, int cstep, int crate);
      int rb, cur, d, s, guard;
      rb = m_mf + (m_n - cn) * 8;
      if (cn < 2 || rb < -65536 || rb > 65535) begin
         m_err = 1'b1;
         return;
      end
      q_wait.push_back(1); q_n.push_back(cn); q_mf.push_back(rb);
      cur = rb;
      guard = 0;
      while (cur != cmf && guard < 200000) begin
         d = cmf - cur;
         if (cstep == 0 || (d < 0 ? -d : d) <= cstep) s = d;
         else s = (d > 0) ? cstep : -cstep;
         cur = cur + s;
         q_wait.push_back(crate + 1); q_n.push_back(cn); q_mf.push_back(cur);
         guard++;
      end
   endfunction

   always @(posedge clk) begin
      if (rst) begin
         m_n = 1000; m_mf = 0; m_err = 1'b0;
         q_wait.delete(); q_n.delete(); q_mf.delete();
         m_live = 1'b1;
      end else begin
         idle_pre = (q_mf.size() == 0);
         m_err = 1'b0;
         if (!idle_pre && div_count == '0 && !hold) begin
            q_wait[0] = q_wait[0] - 1;
            if (q_wait[0] == 0) begin
               m_n  = q_n.pop_front();
               m_mf = q_mf.pop_front();
               void'(q_wait.pop_front());
            end
         end
         if (idle_pre && cfg_if.cfg_valid)
            model_accept(int'(cfg_if.cfg_n), int'(cfg_if.cfg_mf),
                         int'(cfg_if.cfg_step), int'(cfg_if.cfg_rate));
      end
   end

   // Every-cycle comparison against the model.
   always @(negedge clk) begin
      if (m_live) begin
         chk("div_n", int'(div_n), m_n);
         chk("div_mf", int'(div_mf), m_mf);
         chk("busy", int'(busy), int'(q_mf.size() != 0));
         chk("locked", int'(locked), int'(q_mf.size() == 0));
         chk("cfg_ready", int'(cfg_if.cfg_ready), int'(q_mf.size() == 0));
         chk("cfg_err", int'(cfg_err), int'(m_err));
      end
   end

   task automatic next_bnd();
      bit seen;
      seen = 1'b0;
      for (int i = 0; i < 300 && !seen; i++) begin
         @(posedge clk);
         if (div_count == '0) seen = 1'b1;
      end
      if (!seen) begin
         checks++;
         failures++;
         $display("FAIL bnd_timeout actual=none expected=boundary t=%0t", $time);
      end
      @(negedge clk);
   endtask

   task automatic offer(input int n, input int mf, input int step, input int rate);
      cfg_if.cfg_n     = W'(n);
      cfg_if.cfg_mf    = W'(mf);
      cfg_if.cfg_step  = 8'(step);
      cfg_if.cfg_rate  = 8'(rate);
      cfg_if.cfg_valid = 1'b1;
      @(negedge clk);
      cfg_if.cfg_valid = 1'b0;
   endtask

   int e2[5]  = '{0, 3, 6, 9, 10};
   int e3[13] = '{0, 0, 0, 3, 3, 3, 6, 6, 6, 9, 9, 9, 10};
   int e4[3]  = '{800, 796, 792};
   int cn, rb_est, tgt;

   initial begin
      cfg_if.cfg_valid = 1'b0;
      cfg_if.cfg_n     = '0;
      cfg_if.cfg_mf    = '0;
      cfg_if.cfg_step  = '0;
      cfg_if.cfg_rate  = '0;

      // Reset and idle.
      repeat (2) @(negedge clk);
      rst = 1'b0;
      repeat (20) @(negedge clk);
      chk("lit_rst_n", int'(div_n), 1000);
      chk("lit_rst_mf", int'(div_mf), 0);
      chk("lit_rst_locked", int'(locked), 1);
      chk("lit_rst_busy", int'(busy), 0);
      chk("lit_rst_ready", int'(cfg_if.cfg_ready), 1);
      repeat (10) next_bnd();
      chk("lit_idle_n", int'(div_n), 1000);
      chk("lit_idle_mf", int'(div_mf), 0);

      // Step 3, rate 0.
      offer(1000, 10, 3, 0);
      for (int i = 0; i < 5; i++) begin
         next_bnd();
         chk("lit_ramp3_mf", int'(div_mf), e2[i]);
      end
      chk("lit_ramp3_busy", int'(busy), 0);
      chk("lit_ramp3_locked", int'(locked), 1);

      // Back to 0 by a jump, then rate 2 with a hold window.
      offer(1000, 0, 0, 0);
      repeat (2) next_bnd();
      chk("lit_jump_mf", int'(div_mf), 0);
      offer(1000, 10, 3, 2);
      for (int i = 0; i < 4; i++) begin
         next_bnd();
         chk("lit_rate2_mf", int'(div_mf), e3[i]);
      end
      hold = 1'b1;
      for (int i = 0; i < 5; i++) begin
         next_bnd();
         chk("lit_hold_mf", int'(div_mf), 3);
      end
      hold = 1'b0;
      for (int i = 4; i < 13; i++) begin
         next_bnd();
         chk("lit_rate2_mf", int'(div_mf), e3[i]);
      end
      chk("lit_rate2_locked", int'(locked), 1);

      // Rebase across N: 100 -> 99.
      offer(100, 0, 0, 0);
      repeat (2) next_bnd();
      chk("lit_n100", int'(div_n), 100);
      chk("lit_ratio_pre", int'(div_n) * 8 + int'(div_mf), 800);
      offer(99, 0, 4, 0);
      next_bnd();
      chk("lit_rebase_n", int'(div_n), 99);
      chk("lit_rebase_mf", int'(div_mf), 8);
      chk("lit_ratio", int'(div_n) * 8 + int'(div_mf), e4[0]);
      for (int i = 1; i < 3; i++) begin
         next_bnd();
         chk("lit_ratio", int'(div_n) * 8 + int'(div_mf), e4[i]);
      end

      // Rejections.
      offer(1, 0, 0, 0);
      chk("lit_err_n1", int'(cfg_err), 1);
      chk("lit_err_n1_n", int'(div_n), 99);
      @(negedge clk);
      chk("lit_err_pulse_end", int'(cfg_err), 0);
      offer(2, 0, 0, 0);
      repeat (2) next_bnd();
      chk("lit_n2", int'(div_n), 2);
      offer(17'h1FFFF, 0, 0, 0);
      chk("lit_err_ovf", int'(cfg_err), 1);
      chk("lit_err_ovf_n", int'(div_n), 2);
      chk("lit_err_ovf_mf", int'(div_mf), 0);

      // Offer while busy is ignored.
      offer(2, 5, 1, 0);
      offer(50, 0, 0, 0);
      chk("lit_busy_ready", int'(cfg_if.cfg_ready), 0);
      repeat (6) next_bnd();
      chk("lit_busy_n", int'(div_n), 2);
      chk("lit_busy_mf", int'(div_mf), 5);

      // Reset mid-ramp.
      offer(2, 20, 1, 0);
      repeat (2) next_bnd();
      chk("lit_mid_mf", int'(div_mf), 6);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("lit_rst2_n", int'(div_n), 1000);
      chk("lit_rst2_mf", int'(div_mf), 0);
      chk("lit_rst2_busy", int'(busy), 0);
      chk("lit_rst2_locked", int'(locked), 1);
      offer(1000, 4, 0, 0);
      chk("lit_after_rst_busy", int'(busy), 1);
      repeat (2) next_bnd();
      chk("lit_after_rst_mf", int'(div_mf), 4);

      // Randomized traffic checked by the model.
      rand_per = 1'b1;
      for (int c = 0; c < 15000; c++) begin
         hold = ($urandom_range(0, 7) == 0);
         rst  = ($urandom_range(0, 2999) == 0);
         cn = m_n + int'($urandom_range(0, 6)) - 3;
         if ($urandom_range(0, 15) == 0) cn = ($urandom_range(0, 1) == 0) ? 1 : 131071;
         if (cn < 0) cn = 0;
         rb_est = m_mf + (m_n - cn) * 8;
         tgt = rb_est + int'($urandom_range(0, 80)) - 40;
         if (tgt < -65536 || tgt > 65535) tgt = 0;
         cfg_if.cfg_n     = W'(cn);
         cfg_if.cfg_mf    = W'(tgt);
         cfg_if.cfg_step  = 8'($urandom_range(0, 7));
         cfg_if.cfg_rate  = 8'($urandom_range(0, 3));
         cfg_if.cfg_valid = ($urandom_range(0, 3) == 0);
         @(negedge clk);
      end
      rst = 1'b0;
      hold = 1'b0;
      cfg_if.cfg_valid = 1'b0;
      repeat (2) @(negedge clk);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/frac_div_ramp_ctrl.md
Name: frac_div_ramp_ctrl

Overview:
- Configuration sequencer for the fractional divider. Accepts a new divide target (integer N, signed fractional mf with 3 fractional bits) over a valid/ready handshake.
- Slews the divider's mf input toward the target in bounded steps. Changes are applied only at divider period boundaries, so the output frequency never steps by more than the programmed amount.
- Sits between the register interface and the divider's N/mf inputs, in the sys_clk domain.

Parameters:
- WIDTH, 17, width of N, mf and count; must match the divider.
- FSZE, 3, fractional bits in mf; must match the divider.
- RST_N, 17'd1000, div_n value loaded at reset.

Ports:
- sys_clk  in  1  system clock; all logic on the rising edge.
- sync_rst  in  1  synchronous, active-high reset.
- cfg_valid  in  1  new target offered.
- cfg_ready  out  1  controller can accept a target (IDLE only).
- cfg_n  in  WIDTH  target integer divide.
- cfg_mf  in  WIDTH signed  target fractional offset.
- cfg_step  in  8  max |mf| change per update in LSBs; 0 = jump.
- cfg_rate  in  8  extra divider periods between updates; 0 = every period.
- hold  in  1  freeze ramp while high.
- div_count  in  WIDTH  divider count output; 0 marks a period boundary.
- div_n  out  WIDTH  N driven to the divider.
- div_mf  out  WIDTH signed  mf driven to the divider.
- busy  out  1  ramp in progress.
- locked  out  1  div_mf equals target and not busy.
- cfg_err  out  1  one-cycle pulse: target rejected.

Behaviour:
- Reset values: div_n=RST_N, div_mf=0, state IDLE, cfg_ready=1 from the first cycle after reset, busy=0, locked=1, cfg_err=0, rate counter=0.
- Boundary event bnd = (div_count==0). Updates to div_n/div_mf occur only on the rising edge where bnd=1. Both outputs change on the same edge, so the divider's next falling-edge reload sees a consistent pair.
- States: IDLE, REBASE, RAMP.
- IDLE:
  - cfg_ready=1. A handshake is cfg_valid & cfg_ready.
  - On a handshake, latch tgt_mf, step and rate.
  - Compute rb = div_mf + (div_n - cfg_n) * 2^FSZE in WIDTH+FSZE+2 signed bits.
  - Reject if cfg_n < 2 or rb falls outside the signed WIDTH range: pulse cfg_err, stay in IDLE, leave outputs unchanged.
  - Otherwise go to REBASE, busy=1, locked=0.
- REBASE:
  - At the next bnd, load div_n=cfg_n and div_mf=rb. The effective ratio N + mf/2^FSZE is unchanged.
  - Go to RAMP with rate counter = cfg_rate.
  - If rb==tgt_mf, go to IDLE instead.
- RAMP:
  - At each bnd with hold=0: if the rate counter is nonzero, decrement it.
  - Otherwise move div_mf toward tgt_mf by min(step, |tgt_mf - div_mf|) and reload the rate counter.
  - step=0 means div_mf = tgt_mf in one update.
  - When div_mf reaches tgt_mf, go to IDLE, busy=0, locked=1.
- hold=1 freezes the rate counter and div_mf. bnd events are ignored and not queued.
- cfg_valid during REBASE or RAMP: not accepted (cfg_ready=0), with no side effects.
- bnd in the same cycle as a handshake: that bnd is not used. REBASE waits for the next bnd.
- Sub-step arithmetic is computed at WIDTH+1 bits. div_mf never overshoots tgt_mf and never wraps.
- locked is a registered output: 1 iff state==IDLE and div_mf==tgt_mf. Equivalently, it is set only when a ramp completes and cleared on acceptance.
- sync_rst mid-ramp returns all state and outputs to reset values on the next edge. The ramp is abandoned.

Test Plan:
- Reset, then idle for 20 cycles, then 10 bnd -> div_n=1000, div_mf=0, locked=1, busy=0, cfg_ready=1 throughout.
- cfg n=1000, mf=10, step=3, rate=0; bnd every 16 cycles -> div_mf 0, 0 (REBASE bnd), 3, 6, 9, 10 on successive bnd. Then busy=0, locked=1. No change between bnd.
- Same target with rate=2 -> each step occurs on every 3rd bnd after REBASE. Assert hold for 5 bnd mid-ramp -> no change, and the ramp resumes where it left off.
- From n=100, mf=0: cfg n=99, mf=0, step=4 -> REBASE bnd gives div_n=99, div_mf=8, then 4, 0. The ratio*8 sequence is 800, 800, 796, 792.
- cfg n=1 -> cfg_err pulse, state unchanged. cfg n=0x1FFFF from n=2, mf=0 -> rebase overflow -> cfg_err, outputs unchanged. cfg_valid while busy -> ignored.
- Assert sync_rst two bnd into a ramp -> next edge div_n=RST_N, div_mf=0, busy=0, locked=1. A new cfg is accepted on the following cycle.
